// File: rtl/mini_alu_pipe_if.sv
// Bus bundle for mini_alu_pipe: combinational instruction ROM port plus the LCD byte port.
// LCD handshake: a byte is transferred on the rising edge where oLcdValid & iLcdReady; oLcdData is stable while valid.
interface mini_alu_pipe_if #(
    parameter int IP_W    = 16,
    parameter int INSTR_W = 28
);
    logic [IP_W-1:0]    oIAddress;
    logic [INSTR_W-1:0] iInstruction;
    logic [7:0]         oLcdData;
    logic               oLcdValid;
    logic               iLcdReady;

    modport master (
        output oIAddress, oLcdData, oLcdValid,
        input  iInstruction, iLcdReady
    );

    modport slave (
        input  oIAddress, oLcdData, oLcdValid,
        output iInstruction, iLcdReady
    );
endinterface

// File: rtl/mini_alu_pipe.sv
// Three-stage (fetch/execute/writeback) MiniAlu core with WB->EX forwarding, branch flush and LCD stall.
// Optional halt opcode enabled by defining MINI_ALU_HALT_EN.
module mini_alu_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int IP_W   = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    mini_alu_pipe_if.master bus,
    output logic [7:0]      oLed,
    output logic            oHalted,
    output logic [1:0]      dbgState
);
    localparam int INSTR_W = 4 + 3 * ADDR_W;

    localparam logic [3:0] OP_STO  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SMUL = 4'd4;
    localparam logic [3:0] OP_BLE  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_LED  = 4'd7;
    localparam logic [3:0] OP_LCD  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
`ifdef MINI_ALU_HALT_EN
    localparam logic [3:0] OP_HALT = 4'd15;
`endif
    localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

    typedef enum logic [1:0] {RUN = 2'd0, LCD_WAIT = 2'd1, HALTED = 2'd2} state_e;

    state_e              state, stateNext;
    logic [IP_W-1:0]     ip;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   rf [2**ADDR_W];
    logic                wbValid;
    logic [ADDR_W-1:0]   wbDst;
    logic [DATA_W-1:0]   wbResult;
    logic [7:0]          lcdData;

    logic [3:0]          op;
    logic [ADDR_W-1:0]   dst, src1, src0;
    logic [DATA_W-1:0]   opA, opB, aluResult;
    logic                aluWrite, branchTaken, ledWrite, lcdStart, haltReq, advance;

    assign op   = ir[INSTR_W-1 -: 4];
    assign dst  = ir[3*ADDR_W-1 -: ADDR_W];
    assign src1 = ir[2*ADDR_W-1 -: ADDR_W];
    assign src0 = ir[ADDR_W-1:0];

    // The WB register holds the one result not yet in the RF; bypass it per port.
    assign opA = (wbValid && wbDst == src0) ? wbResult : rf[src0];
    assign opB = (wbValid && wbDst == src1) ? wbResult : rf[src1];

    always_comb begin
        aluResult   = '0;
        aluWrite    = 1'b0;
        branchTaken = 1'b0;
        ledWrite    = 1'b0;
        lcdStart    = 1'b0;
        haltReq     = 1'b0;
        if (state == RUN) begin
            case (op)
                OP_STO:  begin aluResult = DATA_W'({src1, src0}); aluWrite = 1'b1; end
                OP_ADD:  begin aluResult = opA + opB;             aluWrite = 1'b1; end
                OP_SUB:  begin aluResult = opA - opB;             aluWrite = 1'b1; end
                OP_SMUL: begin aluResult = opA * opB;             aluWrite = 1'b1; end
                OP_SHL:  begin aluResult = (opB >= SHIFT_LIMIT) ? '0 : opA << opB; aluWrite = 1'b1; end
                OP_SHR:  begin aluResult = (opB >= SHIFT_LIMIT) ? '0 : opA >> opB; aluWrite = 1'b1; end
                OP_BLE:  branchTaken = (opB <= opA);
                OP_JMP:  branchTaken = 1'b1;
                OP_LED:  ledWrite = 1'b1;
                OP_LCD:  lcdStart = 1'b1;
`ifdef MINI_ALU_HALT_EN
                OP_HALT: haltReq = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:      if (lcdStart) stateNext = LCD_WAIT;
                      else if (haltReq) stateNext = HALTED;
            LCD_WAIT: if (bus.iLcdReady) stateNext = RUN;
            HALTED:   stateNext = HALTED;
            default:  stateNext = RUN;
        endcase
    end

    // Fetch moves on in normal running, or on the edge that completes the LCD handshake.
    assign advance = (state == RUN && !lcdStart && !haltReq) ||
                     (state == LCD_WAIT && bus.iLcdReady);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= RUN;
            ip       <= '0;
            ir       <= '0;
            wbValid  <= 1'b0;
            wbDst    <= '0;
            wbResult <= '0;
            oLed     <= '0;
            lcdData  <= '0;
        end else begin
            state    <= stateNext;
            wbValid  <= aluWrite;
            wbDst    <= dst;
            wbResult <= aluResult;
            if (ledWrite) oLed <= opB[7:0];
            if (lcdStart) lcdData <= {opA[3:0], opB[3:0]};
            if (branchTaken) begin
                ip <= IP_W'(dst);
                ir <= '0;
            end else if (advance) begin
                ip <= ip + IP_W'(1);
                ir <= bus.iInstruction;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (wbValid) rf[wbDst] <= wbResult;
    end

    assign bus.oIAddress = ip;
    assign bus.oLcdData  = lcdData;
    assign bus.oLcdValid = (state == LCD_WAIT);
    assign dbgState      = state;
`ifdef MINI_ALU_HALT_EN
    assign oHalted = (state == HALTED);
`else
    assign oHalted = 1'b0;
`endif
endmodule
